// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MEM_BASE_DEF = 32'd1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: splits a 32-bit load/store into two 16-bit SRAM accesses,
// holding ready low so the pipeline freezes until the word is done.
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BASE      = MEM_BASE_DEF,
  parameter int unsigned SRAM_ADDR_W   = 18,
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            st_val,
  output logic                   ready,
  output logic [31:0]            read_data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic                   r_wr;
  logic [SRAM_ADDR_W-2:0] r_word;
  logic [31:0]            r_st_val;
  logic [31:0]            r_read_data;

  logic                   w_req;
  logic                   w_last;
  logic                   w_active;
  logic                   w_half;
  logic                   w_start;
  logic [31:0]            w_off;
  logic                   w_unused;

  assign w_req    = mem_r_en | mem_w_en;
  assign w_last   = (r_cnt == LAST);
  assign w_active = (r_state == LO) || (r_state == HI);
  assign w_half   = (r_state == HI) ? HALF_HI : HALF_LO;
  assign w_start  = (r_state == IDLE) && w_req;

  // Byte offset from the SRAM window; the top bits simply wrap.
  assign w_off    = alu_result - 32'(MEM_BASE);
  assign w_unused = ^{w_off[31:SRAM_ADDR_W+1], w_off[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt = LO;
          w_cnt_nxt   = 4'd0;
        end
      end
      LO: begin
        if (w_last) begin
          w_state_nxt = HI;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      HI: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_word      <= '0;
      r_st_val    <= 32'd0;
      r_read_data <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) begin
        r_wr     <= mem_w_en;
        r_word   <= w_off[SRAM_ADDR_W:2];
        r_st_val <= st_val;
      end
      if (w_active && !r_wr && w_last) begin
        if (w_half == HALF_HI) begin
          r_read_data[31:16] <= sram_dq_in;
        end else begin
          r_read_data[15:0]  <= sram_dq_in;
        end
      end
    end
  end

  // we_n rises in the last cycle so data stays valid past the write edge.
  assign ready       = ((r_state == IDLE) && !w_req) || (r_state == DONE);
  assign read_data   = r_read_data;
  assign sram_addr   = {r_word, w_half};
  assign sram_dq_oe  = w_active && r_wr;
  assign sram_we_n   = !(w_active && r_wr && !w_last);
  assign sram_oe_n   = !(w_active && !r_wr);
  assign sram_dq_out = !(w_active && r_wr) ? 16'd0 :
                       (w_half == HALF_HI) ? r_st_val[31:16] :
                                             r_st_val[15:0];

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench: directed and random loads/stores against a word-level memory
// model, with timing checked from cycle numbers.
module tb_mem_stage_sram_ctrl;

  localparam int AW    = 18;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          r1, w1, r2, w2;
  logic [31:0]   a1, d1, a2, d2;
  logic          rdy1, rdy2;
  logic [31:0]   rd1, rd2;
  logic [AW-1:0] ad1, ad2;
  logic [15:0]   dqo1, dqo2, dqi1, dqi2;
  logic          oe1, oe2, we1, we2, ron1, ron2;

  logic [15:0] mem1 [DEPTH];
  logic [15:0] mem2 [DEPTH];

  logic [31:0] ref1 [int];
  logic [31:0] ref2 [int];
  logic [31:0] last_rd1, last_rd2;

  int checks = 0;
  int errors = 0;

  mem_stage_sram_ctrl #(.ACCESS_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_r_en(r1), .mem_w_en(w1),
    .alu_result(a1), .st_val(d1),
    .ready(rdy1), .read_data(rd1),
    .sram_addr(ad1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_dq_oe(oe1),
    .sram_we_n(we1), .sram_oe_n(ron1)
  );

  mem_stage_sram_ctrl #(.ACCESS_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .mem_r_en(r2), .mem_w_en(w2),
    .alu_result(a2), .st_val(d2),
    .ready(rdy2), .read_data(rd2),
    .sram_addr(ad2), .sram_dq_out(dqo2),
    .sram_dq_in(dqi2), .sram_dq_oe(oe2),
    .sram_we_n(we2), .sram_oe_n(ron2)
  );

  assign dqi1 = mem1[ad1];
  assign dqi2 = mem2[ad2];

  always @(posedge clk) begin
    if (!we1) mem1[ad1] <= dqo1;
    if (!we2) mem2[ad2] <= dqo2;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'd1024) >> 2;
    return off[16:0];
  endfunction

  function automatic logic [31:0] ref_get(input int which, input int w);
    if (which == 1) return ref1.exists(w) ? ref1[w] : 32'd0;
    return ref2.exists(w) ? ref2[w] : 32'd0;
  endfunction

  task automatic drive(input int which, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    if (which == 1) begin
      r1 = r; w1 = w; a1 = a; d1 = d;
    end else begin
      r2 = r; w2 = w; a2 = a; d2 = d;
    end
  endtask

  // Called at a falling edge; runs one access and returns on the
  // falling edge of the idle cycle that follows DONE, inputs still held.
  task automatic run_op(input int which, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int ac);
    int cyc, we_lo, oe_lo, bad_addr;
    bit done;
    logic rdy, wen, oen;
    logic [AW-1:0] ad, exp_ad;
    logic [16:0] wd;
    logic [31:0] rdv, exp;
    drive(which, r, w, a, d);
    wd = word_of(a);
    cyc = 0; we_lo = 0; oe_lo = 0; bad_addr = 0; done = 0;
    while (!done && cyc < 64) begin
      #1;
      rdy = (which == 1) ? rdy1 : rdy2;
      wen = (which == 1) ? we1 : we2;
      oen = (which == 1) ? ron1 : ron2;
      ad  = (which == 1) ? ad1 : ad2;
      if (rdy) begin
        done = 1;
      end else begin
        if (!wen) we_lo++;
        if (!oen) oe_lo++;
        if (cyc >= 1 && cyc <= 2 * ac) begin
          exp_ad = {wd, (cyc > ac) ? 1'b1 : 1'b0};
          if (ad !== exp_ad) bad_addr++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("ready_latency", cyc, 2 * ac + 1);
    chk("we_low_cycles", we_lo, w ? 2 * (ac - 1) : 0);
    chk("oe_low_cycles", oe_lo, w ? 0 : 2 * ac);
    chk("addr_sequence", bad_addr, 0);
    rdv = (which == 1) ? rd1 : rd2;
    if (w) begin
      if (which == 1) begin
        ref1[int'(wd)] = d;
        chk("sram_lo_half", {16'd0, mem1[{wd, 1'b0}]}, {16'd0, d[15:0]});
        chk("sram_hi_half", {16'd0, mem1[{wd, 1'b1}]}, {16'd0, d[31:16]});
        chk("rd_after_write", rdv, last_rd1);
      end else begin
        ref2[int'(wd)] = d;
        chk("sram_lo_half", {16'd0, mem2[{wd, 1'b0}]}, {16'd0, d[15:0]});
        chk("sram_hi_half", {16'd0, mem2[{wd, 1'b1}]}, {16'd0, d[31:16]});
        chk("rd_after_write", rdv, last_rd2);
      end
    end else begin
      exp = ref_get(which, int'(wd));
      chk("read_data", rdv, exp);
      if (which == 1) last_rd1 = exp;
      else last_rd2 = exp;
    end
    @(negedge clk);
  endtask

  task automatic rand_op(input int which, input int ac);
    bit w;
    logic [31:0] a;
    w = ($urandom_range(0, 1) == 1);
    a = ($urandom_range(0, 5) == 0) ? 32'd1020 :
        32'd1024 + 32'($urandom_range(0, 47));
    run_op(which, !w || ($urandom_range(0, 3) == 0), w, a, $urandom, ac);
    if ($urandom_range(0, 1) == 1) begin
      drive(which, 0, 0, 32'd0, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = 16'd0;
      mem2[i] = 16'd0;
    end
    mem1[4] = 16'h5678;
    mem1[5] = 16'h1234;
    ref1[2] = 32'h1234_5678;
    last_rd1 = 32'd0;
    last_rd2 = 32'd0;
    drive(1, 0, 0, 32'd0, 32'd0);
    drive(2, 0, 0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, rdy1}, 32'd1);
    chk("rst_read_data", rd1, 32'd0);
    chk("rst_addr", {14'd0, ad1}, 32'd0);
    chk("rst_strobes", {29'd0, we1, ron1, oe1}, {29'd0, 3'b110});
    chk("rst_dq_out", {16'd0, dqo1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(1, 0, 1, 32'd1024, 32'hDEAD_BEEF, 3);
    chk("write_hw0", {16'd0, mem1[0]}, 32'h0000_BEEF);
    chk("write_hw1", {16'd0, mem1[1]}, 32'h0000_DEAD);
    drive(1, 0, 0, 32'd0, 32'd0);
    @(negedge clk);

    run_op(1, 1, 0, 32'd1032, 32'd0, 3);
    chk("read_directed", rd1, 32'h1234_5678);
    drive(1, 0, 0, 32'd0, 32'd0);
    @(negedge clk);

    run_op(1, 0, 1, 32'd1040, 32'h0000_CAFE, 3);
    run_op(1, 1, 0, 32'd1040, 32'd0, 3);
    chk("b2b_read", rd1, 32'h0000_CAFE);
    drive(1, 0, 0, 32'd0, 32'd0);
    @(negedge clk);

    drive(1, 1, 0, 32'd1032, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_ready", {31'd0, rdy1}, 32'd1);
    chk("midrst_read_data", rd1, 32'd0);
    chk("midrst_strobes", {29'd0, we1, ron1, oe1}, {29'd0, 3'b110});
    last_rd1 = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(1, 1, 1, 32'd1027, 32'h0000_0001, 3);
    chk("conflict_hw0", {16'd0, mem1[0]}, 32'h0000_0001);
    chk("conflict_hw1", {16'd0, mem1[1]}, 32'h0000_0000);
    drive(1, 0, 0, 32'd0, 32'd0);
    @(negedge clk);

    run_op(2, 0, 1, 32'd1028, 32'hA5A5_3C3C, 2);
    run_op(2, 1, 0, 32'd1028, 32'd0, 2);
    chk("sweep_read", rd2, 32'hA5A5_3C3C);
    drive(2, 0, 0, 32'd0, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 24; i++) rand_op(1, 3);
    drive(1, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) rand_op(2, 2);
    drive(2, 0, 0, 32'd0, 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
